alu_ctrl_idex: RTL and testbench

Instruction-decode-to-execute control stage for the pipelined MIPS core: decodes a 32-bit instruction from the ID stage into the ALU's `ALUFun`/`sign` controls, operand selects and extended immediate, and registers them into the ID/EX pipeline register. It handles the producer side of the ALU control interface, with stall/flush handling and illegal-instruction detection. The ALU in EX consumes these outputs combinationally.

---
 rtl/alu_ctrl_idex_if.sv | 30 +++
 rtl/alu_ctrl_idex.sv | 162 ++++++++++++++++
 tb/tb_alu_ctrl_idex.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/alu_ctrl_idex_if.sv
// Bundle between the ID stage and the ID/EX control register: decode inputs,
// pipeline controls and the registered ALU control outputs.
interface alu_ctrl_idex_if;
    logic [31:0] Instruction;
    logic        InValid;
    logic        Stall;
    logic        Flush;
    logic        OutValid;
    logic [5:0]  ALUFun;
    logic        Sign;
    logic        ALUSrcA;
    logic        ALUSrcB;
    logic [4:0]  Shamt;
    logic [31:0] ImmExt;
    logic        RegWrite;
    logic        Illegal;
    logic        IllegalSticky;

    modport master (
        output Instruction, InValid, Stall, Flush,
        input  OutValid, ALUFun, Sign, ALUSrcA, ALUSrcB, Shamt, ImmExt,
               RegWrite, Illegal, IllegalSticky
    );

    modport slave (
        input  Instruction, InValid, Stall, Flush,
        output OutValid, ALUFun, Sign, ALUSrcA, ALUSrcB, Shamt, ImmExt,
               RegWrite, Illegal, IllegalSticky
    );
endinterface

// File: rtl/alu_ctrl_idex.sv
// MIPS ID-stage ALU control decoder feeding the ID/EX pipeline register,
// with stall/flush handling and illegal-instruction tracking.
module alu_ctrl_idex #(
    parameter int IMM_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    alu_ctrl_idex_if.slave   bus
);
    localparam logic [5:0] FUN_ADD = 6'b000000;
    localparam logic [5:0] FUN_SUB = 6'b000001;
    localparam logic [5:0] FUN_AND = 6'b011000;
    localparam logic [5:0] FUN_OR  = 6'b011110;
    localparam logic [5:0] FUN_XOR = 6'b010110;
    localparam logic [5:0] FUN_NOR = 6'b010001;
    localparam logic [5:0] FUN_SLL = 6'b100000;
    localparam logic [5:0] FUN_SRL = 6'b100001;
    localparam logic [5:0] FUN_SRA = 6'b100011;
    localparam logic [5:0] FUN_EQ  = 6'b110011;
    localparam logic [5:0] FUN_NE  = 6'b110001;
    localparam logic [5:0] FUN_LT  = 6'b110101;
    localparam logic [5:0] FUN_LEZ = 6'b111101;
    localparam logic [5:0] FUN_LTZ = 6'b111011;
    localparam logic [5:0] FUN_GTZ = 6'b111111;

    typedef struct packed {
        logic        valid;
        logic [5:0]  fun;
        logic        sign;
        logic        src_a;
        logic        src_b;
        logic [4:0]  shamt;
        logic [31:0] imm;
        logic        reg_write;
        logic        illegal;
    } slot_t;

    slot_t slot_q, slot_d, dec;
    logic  sticky_q, sticky_d;
    logic  legal;

    logic [5:0]       opcode;
    logic [5:0]       funct;
    logic [4:0]       rt;
    logic [IMM_W-1:0] imm;
    logic [31:0]      imm_sext;
    logic [31:0]      imm_zext;
    logic             unused_rs;

    assign opcode    = bus.Instruction[31:26];
    assign funct     = bus.Instruction[5:0];
    assign rt        = bus.Instruction[20:16];
    assign imm       = bus.Instruction[IMM_W-1:0];
    assign imm_sext  = {{(32-IMM_W){imm[IMM_W-1]}}, imm};
    assign imm_zext  = {{(32-IMM_W){1'b0}}, imm};
    assign unused_rs = ^bus.Instruction[25:21];

    always_comb begin
        dec       = '0;
        dec.valid = 1'b1;
        dec.sign  = 1'b1;
        dec.imm   = imm_sext;
        legal     = 1'b1;
        case (opcode)
            6'b000000: begin
                dec.reg_write = 1'b1;
                case (funct)
                    6'b100000: dec.fun = FUN_ADD;
                    6'b100001: begin dec.fun = FUN_ADD; dec.sign = 1'b0; end
                    6'b100010: dec.fun = FUN_SUB;
                    6'b100011: begin dec.fun = FUN_SUB; dec.sign = 1'b0; end
                    6'b100100: dec.fun = FUN_AND;
                    6'b100101: dec.fun = FUN_OR;
                    6'b100110: dec.fun = FUN_XOR;
                    6'b100111: dec.fun = FUN_NOR;
                    6'b101010: dec.fun = FUN_LT;
                    6'b101011: begin dec.fun = FUN_LT; dec.sign = 1'b0; end
                    6'b000000: begin dec.fun = FUN_SLL; dec.src_a = 1'b1; dec.shamt = bus.Instruction[10:6]; end
                    6'b000010: begin dec.fun = FUN_SRL; dec.src_a = 1'b1; dec.shamt = bus.Instruction[10:6]; end
                    6'b000011: begin dec.fun = FUN_SRA; dec.src_a = 1'b1; dec.shamt = bus.Instruction[10:6]; end
                    6'b000100: dec.fun = FUN_SLL;
                    6'b000110: dec.fun = FUN_SRL;
                    6'b000111: dec.fun = FUN_SRA;
                    6'b001000: begin dec.fun = FUN_ADD; dec.reg_write = 1'b0; end
                    6'b001001: dec.fun = FUN_ADD;
                    default:   legal = 1'b0;
                endcase
            end
            6'b001000: begin dec.fun = FUN_ADD; dec.src_b = 1'b1; dec.reg_write = 1'b1; end
            6'b001001: begin dec.fun = FUN_ADD; dec.src_b = 1'b1; dec.reg_write = 1'b1; dec.sign = 1'b0; end
            6'b100011: begin dec.fun = FUN_ADD; dec.src_b = 1'b1; dec.reg_write = 1'b1; end
            6'b101011: begin dec.fun = FUN_ADD; dec.src_b = 1'b1; end
            6'b001010: begin dec.fun = FUN_LT;  dec.src_b = 1'b1; dec.reg_write = 1'b1; end
            6'b001011: begin dec.fun = FUN_LT;  dec.src_b = 1'b1; dec.reg_write = 1'b1; dec.sign = 1'b0; end
            6'b001100: begin dec.fun = FUN_AND; dec.src_b = 1'b1; dec.reg_write = 1'b1; dec.imm = imm_zext; end
            6'b001101: begin dec.fun = FUN_OR;  dec.src_b = 1'b1; dec.reg_write = 1'b1; dec.imm = imm_zext; end
            6'b001110: begin dec.fun = FUN_XOR; dec.src_b = 1'b1; dec.reg_write = 1'b1; dec.imm = imm_zext; end
            // lui: shift the zero-extended immediate left by a constant 16
            6'b001111: begin
                dec.fun       = FUN_SLL;
                dec.src_a     = 1'b1;
                dec.shamt     = 5'd16;
                dec.src_b     = 1'b1;
                dec.imm       = imm_zext;
                dec.reg_write = 1'b1;
            end
            6'b000100: dec.fun = FUN_EQ;
            6'b000101: dec.fun = FUN_NE;
            6'b000110: dec.fun = FUN_LEZ;
            6'b000111: dec.fun = FUN_GTZ;
            6'b000001: begin
                dec.fun = FUN_LTZ;
                legal   = (rt == 5'd0);
            end
            6'b000010: dec.fun = FUN_ADD;
            6'b000011: begin dec.fun = FUN_ADD; dec.reg_write = 1'b1; end
            default:   legal = 1'b0;
        endcase
        if (!legal) begin
            dec         = '0;
            dec.valid   = 1'b1;
            dec.illegal = 1'b1;
        end
    end

    // Flush beats stall; the sticky flag only sees instructions actually loaded.
    always_comb begin
        slot_d   = slot_q;
        sticky_d = sticky_q;
        if (bus.Flush) begin
            slot_d = '0;
        end else if (bus.Stall) begin
            slot_d = slot_q;
        end else if (!bus.InValid) begin
            slot_d = '0;
        end else begin
            slot_d   = dec;
            sticky_d = sticky_q | dec.illegal;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            slot_q   <= '0;
            sticky_q <= 1'b0;
        end else begin
            slot_q   <= slot_d;
            sticky_q <= sticky_d;
        end
    end

    assign bus.OutValid      = slot_q.valid;
    assign bus.ALUFun        = slot_q.fun;
    assign bus.Sign          = slot_q.sign;
    assign bus.ALUSrcA       = slot_q.src_a;
    assign bus.ALUSrcB       = slot_q.src_b;
    assign bus.Shamt         = slot_q.shamt;
    assign bus.ImmExt        = slot_q.imm;
    assign bus.RegWrite      = slot_q.reg_write;
    assign bus.Illegal       = slot_q.illegal;
    assign bus.IllegalSticky = sticky_q;
endmodule

// File: tb/tb_alu_ctrl_idex.sv
// Directed plus randomized checks of alu_ctrl_idex against a table-driven
// instruction model and a priority-ordered load model.
module tb_alu_ctrl_idex;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    alu_ctrl_idex_if bus ();
    alu_ctrl_idex #(.IMM_W(16)) dut (.clk(clk), .reset(reset), .bus(bus));

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic [5:0] op;
        logic [5:0] fn;
        bit         use_fn;
        bit         use_rt;
        logic [5:0] alu;
        bit         sgn;
        bit         sa;
        bit         sb;
        bit         rw;
        int         shk;   // 0: none, 1: instr[10:6], 2: constant 16
        bit         zx;
    } ent_t;
    ent_t tbl[$];

    logic        e_valid, e_sign, e_sa, e_sb, e_rw, e_ill, e_sticky;
    logic [5:0]  e_fun;
    logic [4:0]  e_sh;
    logic [31:0] e_imm;

    task automatic ent(input logic [5:0] op, input logic [5:0] fn, input bit use_fn, input bit use_rt,
                       input logic [5:0] alu, input bit sgn, input bit sa, input bit sb, input bit rw,
                       input int shk, input bit zx);
        ent_t e;
        e.op = op; e.fn = fn; e.use_fn = use_fn; e.use_rt = use_rt; e.alu = alu;
        e.sgn = sgn; e.sa = sa; e.sb = sb; e.rw = rw; e.shk = shk; e.zx = zx;
        tbl.push_back(e);
    endtask

    function automatic int lookup(logic [31:0] w);
        foreach (tbl[i])
            if (tbl[i].op == w[31:26] && (!tbl[i].use_fn || tbl[i].fn == w[5:0]) &&
                (!tbl[i].use_rt || w[20:16] == 5'd0))
                return i;
        return -1;
    endfunction

    task automatic clear_slot();
        e_valid = 0; e_fun = '0; e_sign = 0; e_sa = 0; e_sb = 0; e_sh = '0; e_imm = '0; e_rw = 0; e_ill = 0;
    endtask

    task automatic model_edge(input logic [31:0] w, input bit inv, input bit stall, input bit flush, input bit rst);
        int k;
        if (rst) begin
            clear_slot(); e_sticky = 0;
        end else if (flush || (!stall && !inv)) begin
            clear_slot();
        end else if (!stall) begin
            k = lookup(w);
            clear_slot();
            e_valid = 1;
            if (k < 0) begin
                e_ill = 1; e_sticky = 1;
            end else begin
                e_fun = tbl[k].alu; e_sign = tbl[k].sgn; e_sa = tbl[k].sa; e_sb = tbl[k].sb; e_rw = tbl[k].rw;
                e_sh  = (tbl[k].shk == 1) ? w[10:6] : (tbl[k].shk == 2) ? 5'd16 : 5'd0;
                e_imm = tbl[k].zx ? {16'h0, w[15:0]} : {{16{w[15]}}, w[15:0]};
            end
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".OutValid"}, 32'(bus.OutValid), 32'(e_valid));
        chk({tag, ".Illegal"}, 32'(bus.Illegal), 32'(e_ill));
        chk({tag, ".ALUFun"}, 32'(bus.ALUFun), 32'(e_fun));
        chk({tag, ".RegWrite"}, 32'(bus.RegWrite), 32'(e_rw));
        chk({tag, ".Sticky"}, 32'(bus.IllegalSticky), 32'(e_sticky));
        if (!e_ill) begin
            chk({tag, ".Sign"}, 32'(bus.Sign), 32'(e_sign));
            chk({tag, ".SrcA"}, 32'(bus.ALUSrcA), 32'(e_sa));
            chk({tag, ".SrcB"}, 32'(bus.ALUSrcB), 32'(e_sb));
            chk({tag, ".Shamt"}, 32'(bus.Shamt), 32'(e_sh));
            chk({tag, ".ImmExt"}, bus.ImmExt, e_imm);
        end
    endtask

    task automatic step(input string tag, input logic [31:0] w, input bit inv, input bit stall,
                        input bit flush, input bit rst);
        bus.Instruction = w; bus.InValid = inv; bus.Stall = stall; bus.Flush = flush; reset = rst;
        @(posedge clk);
        model_edge(w, inv, stall, flush, rst);
        #1;
        check_all(tag);
        $display("%-10s instr=%08h v=%0b st=%0b fl=%0b rs=%0b -> ov=%0b fun=%06b rw=%0b ill=%0b stk=%0b",
                 tag, w, inv, stall, flush, rst, bus.OutValid, bus.ALUFun, bus.RegWrite,
                 bus.Illegal, bus.IllegalSticky);
    endtask

    initial begin
        logic [31:0] w;
        int          k;
        // R-type
        ent(6'o00, 6'b100000, 1, 0, 6'b000000, 1, 0, 0, 1, 0, 0);
        ent(6'o00, 6'b100001, 1, 0, 6'b000000, 0, 0, 0, 1, 0, 0);
        ent(6'o00, 6'b100010, 1, 0, 6'b000001, 1, 0, 0, 1, 0, 0);
        ent(6'o00, 6'b100011, 1, 0, 6'b000001, 0, 0, 0, 1, 0, 0);
        ent(6'o00, 6'b100100, 1, 0, 6'b011000, 1, 0, 0, 1, 0, 0);
        ent(6'o00, 6'b100101, 1, 0, 6'b011110, 1, 0, 0, 1, 0, 0);
        ent(6'o00, 6'b100110, 1, 0, 6'b010110, 1, 0, 0, 1, 0, 0);
        ent(6'o00, 6'b100111, 1, 0, 6'b010001, 1, 0, 0, 1, 0, 0);
        ent(6'o00, 6'b101010, 1, 0, 6'b110101, 1, 0, 0, 1, 0, 0);
        ent(6'o00, 6'b101011, 1, 0, 6'b110101, 0, 0, 0, 1, 0, 0);
        ent(6'o00, 6'b000000, 1, 0, 6'b100000, 1, 1, 0, 1, 1, 0);
        ent(6'o00, 6'b000010, 1, 0, 6'b100001, 1, 1, 0, 1, 1, 0);
        ent(6'o00, 6'b000011, 1, 0, 6'b100011, 1, 1, 0, 1, 1, 0);
        ent(6'o00, 6'b000100, 1, 0, 6'b100000, 1, 0, 0, 1, 0, 0);
        ent(6'o00, 6'b000110, 1, 0, 6'b100001, 1, 0, 0, 1, 0, 0);
        ent(6'o00, 6'b000111, 1, 0, 6'b100011, 1, 0, 0, 1, 0, 0);
        ent(6'o00, 6'b001000, 1, 0, 6'b000000, 1, 0, 0, 0, 0, 0);
        ent(6'o00, 6'b001001, 1, 0, 6'b000000, 1, 0, 0, 1, 0, 0);
        // I-type
        ent(6'b001000, 6'd0, 0, 0, 6'b000000, 1, 0, 1, 1, 0, 0);
        ent(6'b001001, 6'd0, 0, 0, 6'b000000, 0, 0, 1, 1, 0, 0);
        ent(6'b100011, 6'd0, 0, 0, 6'b000000, 1, 0, 1, 1, 0, 0);
        ent(6'b101011, 6'd0, 0, 0, 6'b000000, 1, 0, 1, 0, 0, 0);
        ent(6'b001010, 6'd0, 0, 0, 6'b110101, 1, 0, 1, 1, 0, 0);
        ent(6'b001011, 6'd0, 0, 0, 6'b110101, 0, 0, 1, 1, 0, 0);
        ent(6'b001100, 6'd0, 0, 0, 6'b011000, 1, 0, 1, 1, 0, 1);
        ent(6'b001101, 6'd0, 0, 0, 6'b011110, 1, 0, 1, 1, 0, 1);
        ent(6'b001110, 6'd0, 0, 0, 6'b010110, 1, 0, 1, 1, 0, 1);
        ent(6'b001111, 6'd0, 0, 0, 6'b100000, 1, 1, 1, 1, 2, 1);
        // branches and jumps
        ent(6'b000100, 6'd0, 0, 0, 6'b110011, 1, 0, 0, 0, 0, 0);
        ent(6'b000101, 6'd0, 0, 0, 6'b110001, 1, 0, 0, 0, 0, 0);
        ent(6'b000110, 6'd0, 0, 0, 6'b111101, 1, 0, 0, 0, 0, 0);
        ent(6'b000111, 6'd0, 0, 0, 6'b111111, 1, 0, 0, 0, 0, 0);
        ent(6'b000001, 6'd0, 0, 1, 6'b111011, 1, 0, 0, 0, 0, 0);
        ent(6'b000010, 6'd0, 0, 0, 6'b000000, 1, 0, 0, 0, 0, 0);
        ent(6'b000011, 6'd0, 0, 0, 6'b000000, 1, 0, 0, 1, 0, 0);

        clear_slot(); e_sticky = 0;

        step("reset", 32'h2128FFFC, 1, 0, 0, 1);
        step("addi", 32'h2128FFFC, 1, 0, 0, 0);
        chk("addi_imm", bus.ImmExt, 32'hFFFFFFFC);
        step("sra", 32'h00084083, 1, 0, 0, 0);
        chk("sra_fun", 32'(bus.ALUFun), 32'b100011);
        chk("sra_shamt", 32'(bus.Shamt), 32'd2);
        step("lui", 32'h3C081234, 1, 0, 0, 0);
        chk("lui_imm", bus.ImmExt, 32'h00001234);
        step("sltiu", 32'h2D08FFFF, 1, 0, 0, 0);
        chk("sltiu_imm", bus.ImmExt, 32'hFFFFFFFF);
        step("andi", 32'h3108FFFF, 1, 0, 0, 0);
        chk("andi_imm", bus.ImmExt, 32'h0000FFFF);
        step("beq", 32'h11090004, 1, 0, 0, 0);
        step("stall1", 32'h2128FFFC, 1, 1, 0, 0);
        step("stall2", 32'hFC000000, 1, 1, 0, 0);
        step("stall3", 32'h3C081234, 0, 1, 0, 0);
        chk("stall_fun", 32'(bus.ALUFun), 32'b110011);
        step("stfl", 32'h2128FFFC, 1, 1, 1, 0);
        chk("stfl_valid", 32'(bus.OutValid), 32'd0);
        step("illegal", 32'hFC000000, 1, 0, 0, 0);
        chk("ill_sticky", 32'(bus.IllegalSticky), 32'd1);
        step("legal", 32'h00851020, 1, 0, 0, 0);
        step("bubble", 32'h00851020, 0, 0, 0, 0);
        step("rst_stfl", 32'h00851020, 1, 1, 1, 1);
        step("ill_fl", 32'hFC000000, 1, 0, 1, 0);
        chk("illfl_sticky", 32'(bus.IllegalSticky), 32'd0);
        step("regimm1", 32'h04210010, 1, 0, 0, 0);
        step("regimm0", 32'h04200010, 1, 0, 0, 0);

        for (int i = 0; i < 400; i++) begin
            w = $urandom;
            if ($urandom_range(0, 9) < 6) begin
                k = $urandom_range(0, tbl.size() - 1);
                w[31:26] = tbl[k].op;
                if (tbl[k].use_fn) w[5:0] = tbl[k].fn;
                if (tbl[k].use_rt) w[20:16] = 5'd0;
            end
            step("rand", w, $urandom_range(0, 99) < 85, $urandom_range(0, 99) < 20,
                 $urandom_range(0, 99) < 10, $urandom_range(0, 99) < 2);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
